// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster timing constants shared by the sync generator
// and its axis counters.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEFAULT_H_VISIBLE = 640;
    localparam int DEFAULT_H_FRONT   = 16;
    localparam int DEFAULT_H_SYNC    = 96;
    localparam int DEFAULT_H_BACK    = 48;

    localparam int DEFAULT_V_VISIBLE = 480;
    localparam int DEFAULT_V_FRONT   = 10;
    localparam int DEFAULT_V_SYNC    = 2;
    localparam int DEFAULT_V_BACK    = 33;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int H_TOTAL = axis_total(DEFAULT_H_VISIBLE, DEFAULT_H_FRONT,
                                        DEFAULT_H_SYNC, DEFAULT_H_BACK);
    localparam int V_TOTAL = axis_total(DEFAULT_V_VISIBLE, DEFAULT_V_FRONT,
                                        DEFAULT_V_SYNC, DEFAULT_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with registered sync/wrap decodes taken
// from the next-state count, plus a terminal-count strobe for chaining axes.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = DEFAULT_H_VISIBLE,
    parameter int FRONT   = DEFAULT_H_FRONT,
    parameter int SYNC    = DEFAULT_H_SYNC,
    parameter int BACK    = DEFAULT_H_BACK
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    output logic [COORD_W-1:0] count_o,
    output logic               tc_o,
    output logic               wrap_o,
    output logic               sync_n_o,
    output logic               active_next_o
);

    localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

    if (TOTAL > (1 << COORD_W)) begin : g_total_too_big
        $error("vga_axis_counter: axis total %0d exceeds %0d", TOTAL, 1 << COORD_W);
    end
    if (TOTAL < 2) begin : g_total_too_small
        $error("vga_axis_counter: axis total %0d must be at least 2", TOTAL);
    end

    localparam logic [COORD_W-1:0] LAST      = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W:0]   VIS_END   = (COORD_W + 1)'(VISIBLE);
    localparam logic [COORD_W:0]   SYNC_BEG  = (COORD_W + 1)'(VISIBLE + FRONT);
    localparam logic [COORD_W:0]   SYNC_END  = (COORD_W + 1)'(VISIBLE + FRONT + SYNC);

    logic [COORD_W-1:0] count_q, count_d;
    logic               wrap_q, wrap_d;
    logic               sync_n_q, sync_n_d;
    logic               active_d;
    logic               tc;
    logic [COORD_W:0]   count_ext;

    always_comb begin
        tc        = en_i && (count_q == LAST);
        count_d   = count_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
        // One guard bit so an end bound equal to 2**COORD_W still compares.
        count_ext = {1'b0, count_d};
        active_d  = count_ext < VIS_END;
        sync_n_d  = !((count_ext >= SYNC_BEG) && (count_ext < SYNC_END));
        wrap_d    = tc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wrap_q   <= 1'b0;
            sync_n_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign count_o       = count_q;
    assign tc_o          = tc;
    assign wrap_o        = wrap_q;
    assign sync_n_o      = sync_n_q;
    assign active_next_o = active_d;

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 Hz raster timing generator; define VGA_FRAME_COUNTER_EN to add
// an 8-bit frame_count output that advances with every frame_start.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEFAULT_H_VISIBLE,
    parameter int H_FRONT   = DEFAULT_H_FRONT,
    parameter int H_SYNC    = DEFAULT_H_SYNC,
    parameter int H_BACK    = DEFAULT_H_BACK,
    parameter int V_VISIBLE = DEFAULT_V_VISIBLE,
    parameter int V_FRONT   = DEFAULT_V_FRONT,
    parameter int V_SYNC    = DEFAULT_V_SYNC,
    parameter int V_BACK    = DEFAULT_V_BACK
) (
    input  logic               clk,
    input  logic               rst,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
`ifdef VGA_FRAME_COUNTER_EN
    output logic [7:0]         frame_count,
`endif
    output logic               frame_start
);

    logic h_tc, h_active_next;
    logic v_tc, v_active_next;
    logic display_on_q, display_on_d;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (1'b1),
        .count_o       (x),
        .tc_o          (h_tc),
        .wrap_o        (line_start),
        .sync_n_o      (hsync),
        .active_next_o (h_active_next)
    );

    // The vertical axis steps on the same edge that wraps x back to 0.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (h_tc),
        .count_o       (y),
        .tc_o          (v_tc),
        .wrap_o        (frame_start),
        .sync_n_o      (vsync),
        .active_next_o (v_active_next)
    );

    assign display_on_d = h_active_next && v_active_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display_on_q <= 1'b1;
        end else begin
            display_on_q <= display_on_d;
        end
    end

    assign display_on = display_on_q;

`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] frame_count_q, frame_count_d;

    // Advances together with frame_start so both show the new frame at once.
    always_comb begin
        frame_count_d = frame_count_q;
        if (v_tc) begin
            frame_count_d = frame_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count_q <= 8'd0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`else
    logic unused_v_tc;
    assign unused_v_tc = v_tc;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Shrunken-frame bench for vga_sync_gen: every cycle is compared against a
// reference computed from the elapsed cycle count since reset release.
`timescale 1ns/1ps
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    localparam int HV = 8, HF = 2, HS = 2, HB = 2;
    localparam int VV = 6, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [COORD_W-1:0] x, y;
    logic               hsync, vsync, display_on, line_start, frame_start;
`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0]         frame_count;
`endif

    int checks   = 0;
    int errors   = 0;
    int t        = 0;
    int glitches = 0;
    int hs_falls = 0;
    int vs_falls = 0;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;

    vga_sync_gen #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .hsync       (hsync),
        .vsync       (vsync),
        .display_on  (display_on),
        .line_start  (line_start),
`ifdef VGA_FRAME_COUNTER_EN
        .frame_count (frame_count),
`endif
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Registered outputs may only move on a rising clock edge or under reset.
    always @(x or y or hsync or vsync or display_on or line_start or frame_start) begin
        if ($time != 0 && rst !== 1'b1 && ($time % 10) != 5) glitches++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    task automatic check_reset(input string pre);
        check({pre, "_x"}, 32'(x), 0);
        check({pre, "_y"}, 32'(y), 0);
        check({pre, "_hsync"}, 32'(hsync), 1);
        check({pre, "_vsync"}, 32'(vsync), 1);
        check({pre, "_display_on"}, 32'(display_on), 1);
        check({pre, "_line_start"}, 32'(line_start), 0);
        check({pre, "_frame_start"}, 32'(frame_start), 0);
`ifdef VGA_FRAME_COUNTER_EN
        check({pre, "_frame_count"}, 32'(frame_count), 0);
`endif
    endtask

    task automatic check_cycle();
        int ex, ey;
        logic ehs, evs, eon, els, efs;
        ex  = t % HT;
        ey  = (t / HT) % VT;
        ehs = !((ex >= HV + HF) && (ex < HV + HF + HS));
        evs = !((ey >= VV + VF) && (ey < VV + VF + VS));
        eon = (ex < HV) && (ey < VV);
        els = (t > 0) && (ex == 0);
        efs = (t > 0) && ((t % FT) == 0);
        check("x", 32'(x), 32'(ex));
        check("y", 32'(y), 32'(ey));
        check("hsync", 32'(hsync), 32'(ehs));
        check("vsync", 32'(vsync), 32'(evs));
        check("display_on", 32'(display_on), 32'(eon));
        check("line_start", 32'(line_start), 32'(els));
        check("frame_start", 32'(frame_start), 32'(efs));
`ifdef VGA_FRAME_COUNTER_EN
        check("frame_count", 32'(frame_count), 32'((t / FT) % 256));
        if (t == FT) check("frame_count_one", 32'(frame_count), 1);
        if (t == 256 * FT) check("frame_count_wrap", 32'(frame_count), 0);
`endif
        if (prev_hs && !hsync) hs_falls++;
        if (prev_vs && !vsync) vs_falls++;
        if (!prev_vs && vsync) check("vsync_rise_t", 32'(t % FT), 32'((VV + VF + VS) * HT));
        prev_hs = hsync;
        prev_vs = vsync;
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst     = 1'b0;
        t       = 0;
        prev_hs = 1'b1;
        prev_vs = 1'b1;
    endtask

    initial begin
        // Reset held across several edges: outputs stay at reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        release_reset();

        // Three full frames of per-cycle comparison.
        hs_falls = 0;
        vs_falls = 0;
        repeat (3 * FT) step();
        check("hsync_falls", 32'(hs_falls), 32'(3 * VT));
        check("vsync_falls", 32'(vs_falls), 3);

        // Asynchronous resets at random points mid-frame.
        for (int k = 0; k < 5; k++) begin
            int run_len, hold;
            run_len = $urandom_range(2 * FT, 1);
            hold    = $urandom_range(3, 1);
            repeat (run_len) step();
            #2 rst = 1'b1;
            #1 check_reset("async_rst");
            repeat (hold) @(posedge clk);
            @(negedge clk);
            check_reset("rst_hold");
            release_reset();
            repeat (FT + 3) step();
        end

`ifdef VGA_FRAME_COUNTER_EN
        release_reset();
        repeat (256 * FT + 5) step();
`else
        repeat (FT) step();
`endif

        check("no_glitch", 32'(glitches), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA raster timing: horizontal/vertical pixel counters, active-low hsync/vsync, display-enable and frame/line markers. Sits at the top of the video path and drives the `x`, `y` and `vsync` inputs of the pattern selector and pattern generators. The pixel generators consume this timing; this block produces it. Runs on the 25.175 MHz (nominal 25 MHz) pixel clock, one pixel per cycle.

## Interface
Parameters (defaults come from `vga_timing_pkg`; overridable so the bench can run shrunken frames):
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: hsync pulse width
- `H_BACK`, 48: horizontal back porch
- `V_VISIBLE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch
- `V_SYNC`, 2: vsync pulse width
- `V_BACK`, 33: vertical back porch

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `x`  out  10  horizontal count, 0..H_TOTAL-1
- `y`  out  10  vertical count, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, active low
- `vsync`  out  1  vertical sync, active low
- `display_on`  out  1  high while (x,y) is in the visible area
- `line_start`  out  1  one-cycle pulse on the cycle x wraps to 0
- `frame_start`  out  1  one-cycle pulse on the cycle (x,y) wraps to (0,0)

## Operation
- H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be ≤ 1024; elaboration errors otherwise.
- x increments every cycle. At x = H_TOTAL-1, x becomes 0 and y increments. At y = V_TOTAL-1 with x = H_TOTAL-1, y also becomes 0.
- hsync is low iff H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
- vsync is low iff V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491, for whole lines.
- display_on = (x < H_VISIBLE) && (y < V_VISIBLE).
- All outputs are registered. Decodes are computed from next-state counts, so every output is consistent with the x and y presented in the same cycle, with no combinational glitches.
- Reset values: x=0, y=0, hsync=1, vsync=1, display_on=1, line_start=0, frame_start=0.
- The first wrap after reset asserts line_start and frame_start. The initial (0,0) state straight out of reset does not.
- Reset asserted mid-frame returns all outputs to their reset values immediately, since reset is asynchronous. Counting resumes from (0,0) on the first clock edge after release.

## Timing
- Line = 800 cycles; frame = 420,000 cycles (≈59.94 Hz at 25.175 MHz).
- The vsync rising edge occurs on the transition to y=492, x=0, i.e. 393,600 cycles after reset release. Downstream frame counters key on this edge.
- line_start and frame_start are high for exactly one cycle, coincident with x=0 (frame_start additionally with y=0).
- There is no input handshake; the block free-runs.

## Configuration
- `VGA_FRAME_COUNTER_EN` defined: adds output `frame_count` [7:0].
  - Reset value 0.
  - Increments on every frame_start cycle; wraps 255→0.
- Macro undefined: no port and no logic for the frame counter.

## Structure
- `vga_timing_pkg` holds:
  - the eight default timing localparams
  - H_TOTAL and V_TOTAL
  - a COORD_W = 10 width constant
- One sub-module, `vga_axis_counter`:
  - parameters: visible, front, sync, back
  - inputs: count enable and asynchronous reset
  - outputs: count, wrap pulse, sync (active low), active
- Instantiated twice:
  - horizontal: enable tied high
  - vertical: enable = horizontal wrap

## Test plan
- Reset, then release and clock 656 cycles → hsync falls with x=656; rises at x=752; display_on falls at x=640.
- Clock 800 cycles from release → x=0, y=1, line_start high for 1 cycle, frame_start low.
- Clock 392,000 cycles from release → vsync low at y=490, x=0; high again at y=492, x=0, exactly 1,600 cycles later.
- Clock 420,000 cycles from release → x=0, y=0, frame_start and line_start both pulse. With `VGA_FRAME_COUNTER_EN`, frame_count=1, and after 256 frames it wraps to 0 (use shrunken parameters, e.g. H 8/2/2/2 and V 6/1/1/1).
- Assert rst at y=300, x=400 → all outputs at reset values with no clock edge needed; after release, the counting sequence repeats exactly from (0,0).
- Shrunken-parameter run over 3 frames:
  - a scoreboard checks every cycle's hsync, vsync and display_on against the decode equations;
  - a check confirms no sync glitches occur.
